instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Multicycle-core fetch stage directly upstream of ControlUnit. Holds PC, OldPC and the instruction register (IR), and runs the instruction-memory read handshake. Acts on ControlUnit's PCWrite/IRWrite strobes and returns op/funct3/funct7_5 plus register-index fields decoded from the IR. Signals fetch_busy so ControlUnit stalls in FETCH until the IR is loaded.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, IR value after reset or abort (addi x0,x0,0)
TIMEOUT_CYCLES, 255, fetch watchdog limit (used only with FETCH_TIMEOUT_EN)

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
PCWrite  in  1  load pc from pc_next
IRWrite  in  1  start a fetch at current pc
pc_next  in  XLEN  next PC from ALU/result mux
mem_req  out  1  instruction read request
mem_addr  out  XLEN  read address, registered
mem_rdata  in  32  read data, valid when mem_ready=1
mem_ready  in  1  read-complete strobe
pc  out  XLEN  current PC
old_pc  out  XLEN  PC of instruction in IR
instr  out  32  instruction register
instr_valid  out  1  one-cycle pulse when IR loaded
fetch_busy  out  1  fetch in progress; ControlUnit must hold
misalign_err  out  1  one-cycle pulse, rejected PC write
fetch_err  out  1  sticky watchdog error
op  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7_5  out  1  instr[30]
rd, rs1, rs2  out  5 each  instr[11:7], instr[19:15], instr[24:20]

Behaviour:
- Reset (sync, any state): pc=old_pc=mem_addr=RESET_PC, instr=NOP_INSTR, state=IDLE, mem_req=0, instr_valid=0, fetch_busy=0, misalign_err=0, fetch_err=0, watchdog=0.
- States: IDLE, REQ, DONE. fetch_busy=1 in REQ and DONE. mem_req=1 only in REQ.
- IDLE + IRWrite: old_pc<=pc, mem_addr<=pc, next REQ. IRWrite in REQ/DONE ignored, no side effects.
- REQ: mem_req and mem_addr held stable until mem_ready=1. On mem_ready: instr<=mem_rdata, next DONE. Minimum IRWrite-to-instr_valid latency 2 cycles (ready in first REQ cycle).
- DONE: instr_valid=1 for exactly this cycle, next IDLE.
- mem_ready outside REQ ignored.
- PCWrite (any state): pc_next[0] forced to 0 (JALR rule). If pc_next[1]=1, pc unchanged and misalign_err pulses next cycle. Otherwise pc<=pc_next.
- PCWrite and IRWrite in the same IDLE cycle (FETCH PC+4): old_pc and mem_addr take pre-update pc; pc takes pc_next.
- PCWrite during REQ updates pc only. In-flight mem_addr is unaffected.
- Decoded fields are combinational from instr. They change only when IR loads or resets.
- Reset mid-REQ: mem_req low from the next cycle; a late mem_ready is ignored.

Optional Feature:
FETCH_TIMEOUT_EN:
- Defined: watchdog counts REQ cycles. If it reaches TIMEOUT_CYCLES without mem_ready, abort: instr<=NOP_INSTR, fetch_err<=1 (sticky until reset), state IDLE, mem_req low, no instr_valid. Counter clears on REQ entry.
- Undefined: REQ waits indefinitely; fetch_err tied 0. Port list is identical in both builds.

Test Plan:
- Reset then release -> pc=0, instr=32'h13, op=7'b0010011, mem_req=0, fetch_busy=0.
- IRWrite+PCWrite with pc_next=4, mem_rdata=32'h00002083 (lw x1,0(x0)), ready after 3 REQ cycles -> mem_addr=0 held throughout, old_pc=0, pc=4, op=7'b0000011, rd=1, instr_valid single pulse.
- IRWrite with mem_ready=1 in first REQ cycle, rdata=32'h40208033 (sub) -> instr_valid 2 cycles after IRWrite, funct7_5=1, funct3=0, op=7'b0110011.
- PCWrite pc_next=32'h0000_0101 -> pc=32'h100. PCWrite pc_next=32'h0000_0102 -> pc stays 32'h100, misalign_err pulses once.
- Reset asserted during REQ, mem_ready arrives next cycle -> mem_req=0, instr stays 32'h13, no instr_valid.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, mem_ready never asserted -> mem_req drops after 8 REQ cycles, fetch_err=1 and held, instr=32'h13. Next IRWrite starts a new fetch.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Instruction-memory read bus between the fetch stage (master) and the
// instruction memory (slave). A read is requested by holding mem_req high with
// a stable mem_addr; the memory completes it by pulsing mem_ready with
// mem_rdata valid in the same cycle.
//
// Signals:
//   mem_req    master->slave  1     read request, held until mem_ready
//   mem_addr   master->slave  XLEN  read address, stable while mem_req=1
//   mem_rdata  slave->master  32    read data, valid when mem_ready=1
//   mem_ready  slave->master  1     read-complete strobe
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic [31:0]     mem_rdata;
  logic            mem_ready;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage of a multicycle core, sitting directly upstream of the control
// unit. Holds PC, OldPC and the instruction register, runs the instruction
// memory read handshake, and decodes the basic fields of the IR.
//
// Optional feature macro: FETCH_TIMEOUT_EN
//   defined   : a watchdog aborts a fetch that sees no mem_ready within
//               TIMEOUT_CYCLES request cycles (IR <= NOP, sticky fetch_err).
//   undefined : a fetch waits for mem_ready indefinitely; fetch_err is 0.
//
// Ports:
//   clock         in   1     system clock, all state on rising edge
//   reset         in   1     synchronous, active-high
//   PCWrite       in   1     load pc from pc_next (bit 0 cleared)
//   IRWrite       in   1     start a fetch at the current pc (IDLE only)
//   pc_next       in   XLEN  next PC from ALU/result mux
//   mem           if   -     instruction-memory read bus (master side)
//   pc            out  XLEN  current PC
//   old_pc        out  XLEN  PC of the instruction in (or being loaded to) IR
//   instr         out  32    instruction register
//   instr_valid   out  1     one-cycle pulse when the IR has been loaded
//   fetch_busy    out  1     fetch in progress; control unit must hold
//   misalign_err  out  1     one-cycle pulse after a rejected PC write
//   fetch_err     out  1     sticky watchdog error
//   op/funct3/funct7_5/rd/rs1/rs2  out  decoded IR fields
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module instr_fetch_unit #(
  parameter int                XLEN           = 32,
  parameter logic [XLEN-1:0]   RESET_PC       = '0,
  parameter logic [31:0]       NOP_INSTR      = 32'h0000_0013,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             IRWrite,
  input  logic [XLEN-1:0]  pc_next,
  instr_fetch_unit_if.master mem,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  old_pc,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic             fetch_busy,
  output logic             misalign_err,
  output logic             fetch_err,
  output logic [6:0]       op,
  output logic [2:0]       funct3,
  output logic             funct7_5,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("instr_fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] old_pc_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [31:0]     instr_q;
  logic            mem_req_q;
  logic            instr_valid_q;
  logic            fetch_busy_q;
  logic            misalign_q;

  // Bit 0 is always cleared (JALR target rule); bit 1 set after that means the
  // target is not word aligned and the write is rejected.
  logic [XLEN-1:0] pc_target_d;
  assign pc_target_d = pc_next & {{(XLEN-1){1'b1}}, 1'b0};

`ifdef FETCH_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_q;
  logic              fetch_err_q;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      old_pc_q      <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      instr_q       <= NOP_INSTR;
      mem_req_q     <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_busy_q  <= 1'b0;
      misalign_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wdog_q        <= '0;
      fetch_err_q   <= 1'b0;
`endif
    end else begin
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;

      // PC update is independent of the fetch FSM; an in-flight fetch keeps
      // using the address captured on entry to REQ.
      if (PCWrite) begin
        if (pc_target_d[1]) begin
          misalign_q <= 1'b1;
        end else begin
          pc_q <= pc_target_d;
        end
      end

      case (state_q)
        S_IDLE: begin
          if (IRWrite) begin
            // pc_q is the pre-update value even if PCWrite fires this cycle.
            old_pc_q     <= pc_q;
            mem_addr_q   <= pc_q;
            mem_req_q    <= 1'b1;
            fetch_busy_q <= 1'b1;
            state_q      <= S_REQ;
`ifdef FETCH_TIMEOUT_EN
            wdog_q       <= '0;
`endif
          end
        end

        S_REQ: begin
          if (mem.mem_ready) begin
            instr_q       <= mem.mem_rdata;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b1;
            state_q       <= S_DONE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wdog_q == WDOG_LAST) begin
            // This was the last permitted request cycle: give up quietly.
            instr_q      <= NOP_INSTR;
            fetch_err_q  <= 1'b1;
            mem_req_q    <= 1'b0;
            fetch_busy_q <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            wdog_q <= wdog_q + WDOG_W'(1);
          end
`endif
        end

        S_DONE: begin
          fetch_busy_q <= 1'b0;
          state_q      <= S_IDLE;
        end

        default: begin
          mem_req_q    <= 1'b0;
          fetch_busy_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;

  assign pc           = pc_q;
  assign old_pc       = old_pc_q;
  assign instr        = instr_q;
  assign instr_valid  = instr_valid_q;
  assign fetch_busy   = fetch_busy_q;
  assign misalign_err = misalign_q;

`ifdef FETCH_TIMEOUT_EN
  assign fetch_err    = fetch_err_q;
`else
  assign fetch_err    = 1'b0;
`endif

  assign op       = instr_q[6:0];
  assign rd       = instr_q[11:7];
  assign funct3   = instr_q[14:12];
  assign rs1      = instr_q[19:15];
  assign rs2      = instr_q[24:20];
  assign funct7_5 = instr_q[30];

endmodule

// File: tb/tb_instr_fetch_unit.sv
`timescale 1ns/1ps

module tb_instr_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        PCWrite;
  logic        IRWrite;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_busy;
  logic        misalign_err;
  logic        fetch_err;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  instr_fetch_unit_if #(.XLEN(32)) mem_bus ();

  instr_fetch_unit #(
    .XLEN           (32),
    .RESET_PC       (32'h0000_0000),
    .NOP_INSTR      (32'h0000_0013),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .PCWrite      (PCWrite),
    .IRWrite      (IRWrite),
    .pc_next      (pc_next),
    .mem          (mem_bus),
    .pc           (pc),
    .old_pc       (old_pc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .fetch_busy   (fetch_busy),
    .misalign_err (misalign_err),
    .fetch_err    (fetch_err),
    .op           (op),
    .funct3       (funct3),
    .funct7_5     (funct7_5),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // Expected result of one fetch, consumed by the monitor on instr_valid.
  typedef struct {
    logic [31:0] instr;
    logic [31:0] old_pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    int          issue;
    int          lat;
  } exp_t;

  // One directed fetch vector; decoded fields are hand-computed.
  typedef struct {
    logic        pcw;
    logic [31:0] pcn;
    logic [31:0] rdata;
    int          waits;
    logic        req_pcw;
    logic [31:0] req_pcn;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f75;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  exp_t        exp_q[$];
  logic [31:0] mis_q[$];
  logic [31:0] pc_model;
  logic [31:0] instr_model;

  function automatic logic [31:0] pc_apply(input logic [31:0] cur, input logic [31:0] nxt);
    if (nxt[1]) return cur;
    return {nxt[31:1], 1'b0};
  endfunction

  // Monitor: compares against scoreboard whenever the DUT presents an output.
  always @(negedge clock) begin
    if (instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("valid_without_fetch", 32'(instr_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("fetch done: old_pc=%h instr=%h op=%b rd=%0d rs1=%0d rs2=%0d f3=%0d f7_5=%0d",
                 old_pc, instr, op, rd, rs1, rs2, funct3, funct7_5);
        check("mon_instr",    instr,          e.instr);
        check("mon_old_pc",   old_pc,         e.old_pc);
        check("mon_op",       32'(op),        32'(e.op));
        check("mon_funct3",   32'(funct3),    32'(e.f3));
        check("mon_funct7_5", 32'(funct7_5),  32'(e.f75));
        check("mon_rd",       32'(rd),        32'(e.rd));
        check("mon_rs1",      32'(rs1),       32'(e.rs1));
        check("mon_rs2",      32'(rs2),       32'(e.rs2));
        check("mon_latency",  32'(cyc - e.issue), 32'(e.lat));
      end
    end
    if (misalign_err === 1'b1) begin
      if (mis_q.size() == 0) begin
        check("misalign_unexpected", 32'(misalign_err), 32'd0);
      end else begin
        logic [31:0] p;
        p = mis_q.pop_front();
        $display("misalign pulse: pc=%h", pc);
        check("mon_misalign_pc", pc, p);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_fetch(input vec_t v);
    exp_t        e;
    logic [31:0] addr;
    addr     = pc_model;
    e.instr  = v.rdata;
    e.old_pc = pc_model;
    e.op     = v.op;
    e.f3     = v.f3;
    e.f75    = v.f75;
    e.rd     = v.rd;
    e.rs1    = v.rs1;
    e.rs2    = v.rs2;
    e.issue  = cyc;
    e.lat    = 2 + v.waits;
    exp_q.push_back(e);
    IRWrite  = 1'b1;
    PCWrite  = v.pcw;
    pc_next  = v.pcn;
    if (v.pcw) pc_model = pc_apply(pc_model, v.pcn);
    tick();
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    for (int k = 0; k < v.waits; k++) begin
      check("req_mem_req",    32'(mem_bus.mem_req), 32'd1);
      check("req_mem_addr",   mem_bus.mem_addr,     addr);
      check("req_old_pc",     old_pc,               addr);
      check("req_pc",         pc,                   pc_model);
      check("req_busy",       32'(fetch_busy),      32'd1);
      check("req_instr_hold", instr,                instr_model);
      IRWrite = 1'b1;  // must be ignored while busy
      if (k == 0 && v.req_pcw) begin
        PCWrite  = 1'b1;
        pc_next  = v.req_pcn;
        pc_model = pc_apply(pc_model, v.req_pcn);
      end
      tick();
      IRWrite = 1'b0;
      PCWrite = 1'b0;
    end
    check("rdy_mem_req",  32'(mem_bus.mem_req), 32'd1);
    check("rdy_mem_addr", mem_bus.mem_addr,     addr);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = v.rdata;
    tick();
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'hFFFF_FFFF;
    instr_model = v.rdata;
    check("done_valid",   32'(instr_valid),     32'd1);
    check("done_busy",    32'(fetch_busy),      32'd1);
    check("done_mem_req", 32'(mem_bus.mem_req), 32'd0);
    check("done_pc",      pc,                   pc_model);
    tick();
    check("idle_valid",   32'(instr_valid),     32'd0);
    check("idle_busy",    32'(fetch_busy),      32'd0);
    check("idle_old_pc",  old_pc,               addr);
    check("idle_instr",   instr,                instr_model);
  endtask

  initial begin
    vec_t v;
    reset             = 1'b1;
    PCWrite           = 1'b0;
    IRWrite           = 1'b0;
    pc_next           = 32'h0;
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'hFFFF_FFFF;
    pc_model          = 32'h0;
    instr_model       = 32'h0000_0013;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_pc",       pc,                   32'h0);
    check("rst_old_pc",   old_pc,               32'h0);
    check("rst_mem_addr", mem_bus.mem_addr,     32'h0);
    check("rst_instr",    instr,                32'h0000_0013);
    check("rst_op",       32'(op),              32'h13);
    check("rst_mem_req",  32'(mem_bus.mem_req), 32'd0);
    check("rst_busy",     32'(fetch_busy),      32'd0);
    check("rst_valid",    32'(instr_valid),     32'd0);
    check("rst_fetch_err",32'(fetch_err),       32'd0);
    check("rst_misalign", 32'(misalign_err),    32'd0);

    // lw x1,0(x0) with PC+4 in the same cycle, ready after 3 REQ cycles
    v = '{1'b1, 32'h4, 32'h0000_2083, 3, 1'b0, 32'h0,
          7'b0000011, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0};
    do_fetch(v);

    // sub x0,x1,x2 with ready in the first REQ cycle (2-cycle latency)
    v = '{1'b0, 32'h0, 32'h4020_8033, 0, 1'b0, 32'h0,
          7'b0110011, 3'd0, 1'b1, 5'd0, 5'd1, 5'd2};
    do_fetch(v);

    // PC writes: bit 0 cleared, bit 1 rejected
    PCWrite = 1'b1;
    pc_next = 32'h0000_0101;
    pc_model = pc_apply(pc_model, pc_next);
    tick();
    PCWrite = 1'b0;
    check("pcw_101_pc",       pc,                32'h0000_0100);
    check("pcw_101_misalign", 32'(misalign_err), 32'd0);
    PCWrite = 1'b1;
    pc_next = 32'h0000_0102;
    mis_q.push_back(32'h0000_0100);
    tick();
    PCWrite = 1'b0;
    check("pcw_102_pc",       pc,                32'h0000_0100);
    check("pcw_102_misalign", 32'(misalign_err), 32'd1);
    tick();
    check("pcw_102_pulse_end",32'(misalign_err), 32'd0);

    // addi x2,x0,5 with a PC write during REQ (address must not move)
    v = '{1'b0, 32'h0, 32'h0050_0113, 2, 1'b1, 32'h0000_0200,
          7'b0010011, 3'd0, 1'b0, 5'd2, 5'd0, 5'd5};
    do_fetch(v);

    // Reset in the middle of REQ, late mem_ready ignored
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    check("abrt_mem_req", 32'(mem_bus.mem_req), 32'd1);
    check("abrt_addr",    mem_bus.mem_addr,     32'h0000_0200);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pc_model    = 32'h0;
    instr_model = 32'h0000_0013;
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = 32'hDEAD_BEEF;
    check("abrt_req_low", 32'(mem_bus.mem_req), 32'd0);
    check("abrt_pc",      pc,                   32'h0);
    check("abrt_instr",   instr,                32'h0000_0013);
    tick();
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'hFFFF_FFFF;
    check("abrt_instr2",  instr,                32'h0000_0013);
    check("abrt_valid",   32'(instr_valid),     32'd0);
    check("abrt_busy",    32'(fetch_busy),      32'd0);

`ifdef FETCH_TIMEOUT_EN
    // Watchdog: no mem_ready for 8 REQ cycles aborts the fetch
    IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check("wd_req_high", 32'(mem_bus.mem_req), 32'd1);
      check("wd_err_low",  32'(fetch_err),       32'd0);
      tick();
    end
    check("wd_req_low",   32'(mem_bus.mem_req), 32'd0);
    check("wd_fetch_err", 32'(fetch_err),       32'd1);
    check("wd_instr",     instr,                32'h0000_0013);
    check("wd_busy",      32'(fetch_busy),      32'd0);
    check("wd_valid",     32'(instr_valid),     32'd0);
    repeat (3) tick();
    check("wd_err_sticky",32'(fetch_err),       32'd1);
    v = '{1'b0, 32'h0, 32'h0000_2083, 3, 1'b0, 32'h0,
          7'b0000011, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0};
    do_fetch(v);
    check("wd_err_after", 32'(fetch_err),       32'd1);
`else
    // No watchdog: a long wait still completes and fetch_err stays 0
    v = '{1'b0, 32'h0, 32'h0000_2083, 20, 1'b0, 32'h0,
          7'b0000011, 3'd2, 1'b0, 5'd1, 5'd0, 5'd0};
    do_fetch(v);
    check("nowd_fetch_err", 32'(fetch_err),     32'd0);
`endif

    repeat (2) tick();
    check("pending_fetches",  32'(exp_q.size()), 32'd0);
    check("pending_misalign", 32'(mis_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
